// File: rtl/core_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_sequencer_if : run control, stage handshakes and status of the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface core_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             halt_req;
  logic             fetch_en;
  logic             decode_en;
  logic             exec_en;
  logic             mem_en;
  logic             write_en;
  logic             fetch_done;
  logic             decode_done;
  logic             exec_done;
  logic             mem_done;
  logic             write_done;
  logic [5:0]       opcode;
  logic             busy;
  logic             halted;
  logic             error;
  logic [2:0]       err_stage;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  // Sequencer side
  modport master (
    input  run, halt_req, opcode,
    input  fetch_done, decode_done, exec_done, mem_done, write_done,
    output fetch_en, decode_en, exec_en, mem_en, write_en,
    output busy, halted, error, err_stage, cycle_count, instr_count
  );

  // Host / stage-module side
  modport slave (
    output run, halt_req, opcode,
    output fetch_done, decode_done, exec_done, mem_done, write_done,
    input  fetch_en, decode_en, exec_en, mem_en, write_en,
    input  busy, halted, error, err_stage, cycle_count, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_sequencer : in-order fetch/decode/exec/mem/write sequencer with opcode
// stage skipping, halt, per-stage timeout and saturating perf counters. Rev 1.0
// ----------------------------------------------------------------------------
module core_sequencer #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 32
) (
  input wire               clk,
  input wire               rstn,
  core_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WRITE  = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [15:0]      TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [15:0]      wait_q, wait_d;
  logic [5:0]       opcode_q, opcode_d;
  logic             error_q, error_d;
  logic [2:0]       err_stage_q, err_stage_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic stage_active;
  logic stage_done;
  logic done_ok;
  logic retire;
  logic needs_write;
  logic is_mem_op;

  function automatic logic is_stage(input state_t s);
    return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
           (s == S_MEM)   || (s == S_WRITE);
  endfunction

  assign stage_active = is_stage(state_q);
  assign is_mem_op    = (opcode_q[5:4] == 2'b10);
  assign needs_write  = !((opcode_q == 6'b000010) || (opcode_q == 6'b000100) ||
                          (opcode_q == 6'b000101) || (opcode_q[5:3] == 3'b101));

  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      S_FETCH:  stage_done = bus.fetch_done;
      S_DECODE: stage_done = bus.decode_done;
      S_EXEC:   stage_done = bus.exec_done;
      S_MEM:    stage_done = bus.mem_done;
      S_WRITE:  stage_done = bus.write_done;
      default:  stage_done = 1'b0;
    endcase
  end

  // A done in the enable cycle itself is not a completion.
  assign done_ok = stage_active && !first_q && stage_done;

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    error_d       = error_q;
    err_stage_d   = err_stage_q;
    instr_count_d = instr_count_q;
    retire        = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: if (bus.run) state_d = S_FETCH;
      S_FETCH:        if (done_ok) state_d = S_DECODE;
      S_DECODE: begin
        if (done_ok) begin
          state_d  = S_EXEC;
          opcode_d = bus.opcode;
        end
      end
      S_EXEC: begin
        if (done_ok) begin
          if (is_mem_op)        state_d = S_MEM;
          else if (needs_write) state_d = S_WRITE;
          else                  retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (done_ok) begin
          if (needs_write) state_d = S_WRITE;
          else             retire  = 1'b1;
        end
      end
      S_WRITE: if (done_ok) retire = 1'b1;
      default: state_d = state_q;
    endcase

    if (retire) begin
      state_d = bus.halt_req ? S_HALT : S_FETCH;
      if (instr_count_q != CNT_MAX) instr_count_d = instr_count_q + 1'b1;
    end

    // A done landing on the timeout cycle has already been taken above.
    if (stage_active && !first_q && !stage_done && (wait_q == TIMEOUT_CNT)) begin
      state_d     = S_ERROR;
      error_d     = 1'b1;
      err_stage_d = 3'(state_q) - 3'd1;
    end

    first_d = is_stage(state_d) && (state_d != state_q);

    if (state_d != state_q) wait_d = '0;
    else if (stage_active)  wait_d = wait_q + 16'd1;
    else                    wait_d = wait_q;

    cycle_count_d = cycle_count_q;
    if (stage_active && (cycle_count_q != CNT_MAX)) cycle_count_d = cycle_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      first_q       <= 1'b0;
      wait_q        <= '0;
      opcode_q      <= '0;
      error_q       <= 1'b0;
      err_stage_q   <= '0;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      wait_q        <= wait_d;
      opcode_q      <= opcode_d;
      error_q       <= error_d;
      err_stage_q   <= err_stage_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.fetch_en    = first_q && (state_q == S_FETCH);
  assign bus.decode_en   = first_q && (state_q == S_DECODE);
  assign bus.exec_en     = first_q && (state_q == S_EXEC);
  assign bus.mem_en      = first_q && (state_q == S_MEM);
  assign bus.write_en    = first_q && (state_q == S_WRITE);
  assign bus.busy        = stage_active;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.error       = error_q;
  assign bus.err_stage   = err_stage_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.instr_count = instr_count_q;
endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_core_sequencer : scoreboard bench for core_sequencer (stage order, halt,
// timeout, spurious dones, reset, counter saturation). Rev 1.0
// ----------------------------------------------------------------------------
module tb_core_sequencer;
  localparam logic [5:0] OP_ALU    = 6'b000000;
  localparam logic [5:0] OP_LOAD   = 6'b100011;
  localparam logic [5:0] OP_STORE  = 6'b101011;
  localparam logic [5:0] OP_BRANCH = 6'b000100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  core_sequencer_if #(.CNT_W(32)) bus ();
  core_sequencer_if #(.CNT_W(4))  bus2 ();

  core_sequencer #(.TIMEOUT(8), .CNT_W(32)) u_dut (.clk(clk), .rstn(rstn), .bus(bus));
  core_sequencer #(.TIMEOUT(8), .CNT_W(4))  u_sat (.clk(clk), .rstn(rstn), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [4:0] en_vec;
  logic [4:0] auto_mask = 5'b11111;
  logic [4:0] auto_q    = '0;
  logic [4:0] man_done  = '0;
  logic [5:0] op        = '0;
  logic [4:0] exp_q[$];
  logic [5:0] prog_q[$];
  logic [4:0] exp_en;

  // Stage models: done one cycle after the enable, unless masked for manual control.
  assign en_vec          = {bus.write_en, bus.mem_en, bus.exec_en, bus.decode_en, bus.fetch_en};
  assign bus.fetch_done  = auto_q[0] | man_done[0];
  assign bus.decode_done = auto_q[1] | man_done[1];
  assign bus.exec_done   = auto_q[2] | man_done[2];
  assign bus.mem_done    = auto_q[3] | man_done[3];
  assign bus.write_done  = auto_q[4] | man_done[4];
  assign bus.opcode      = op;

  logic [4:0] auto2_q = '0;
  assign bus2.run         = 1'b1;
  assign bus2.halt_req    = 1'b0;
  assign bus2.opcode      = OP_ALU;
  assign bus2.fetch_done  = auto2_q[0];
  assign bus2.decode_done = auto2_q[1];
  assign bus2.exec_done   = auto2_q[2];
  assign bus2.mem_done    = auto2_q[3];
  assign bus2.write_done  = auto2_q[4];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    auto_q  <= en_vec & auto_mask;
    auto2_q <= {bus2.write_en, bus2.mem_en, bus2.exec_en, bus2.decode_en, bus2.fetch_en};
    if (bus.fetch_en && (prog_q.size() > 0)) op <= prog_q.pop_front();
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected enable sequence for one instruction, truncated to n stages.
  task automatic push_instr(input logic [5:0] opc, input int n);
    logic [4:0] seq[$];
    seq.push_back(5'b00001);
    seq.push_back(5'b00010);
    seq.push_back(5'b00100);
    if (opc[5:4] == 2'b10) seq.push_back(5'b01000);
    if (!(opc == 6'b000010 || opc == 6'b000100 || opc == 6'b000101 || opc[5:3] == 3'b101))
      seq.push_back(5'b10000);
    for (int i = 0; i < n && i < seq.size(); i++) exp_q.push_back(seq[i]);
    prog_q.push_back(opc);
  endtask

  always @(negedge clk) begin
    if (rstn && (en_vec != 5'b0)) begin
      if (exp_q.size() == 0) check("en_unexpected", 32'(en_vec), 32'd0);
      else begin
        exp_en = exp_q.pop_front();
        check("en_order", 32'(en_vec), 32'(exp_en));
      end
    end
  end

  task automatic wait_en(input int idx, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!en_vec[idx] && n < 60);
    check(tag, 32'(en_vec[idx]), 32'd1);
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!bus.halted && n < 60) begin @(negedge clk); n++; end
    check(tag, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t1;
    bus.run = 1'b0;
    bus.halt_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(en_vec), 32'd0);
    check("rst_status", {28'd0, bus.busy, bus.halted, bus.error, 1'b0}, 32'd0);
    check("rst_err_stage", 32'(bus.err_stage), 32'd0);
    check("rst_cycle", bus.cycle_count, 32'd0);
    check("rst_instr", bus.instr_count, 32'd0);
    rstn = 1'b1;

    // ALU, load, store; halt requested during exec of the store
    push_instr(OP_ALU, 5);
    push_instr(OP_LOAD, 5);
    push_instr(OP_STORE, 5);
    @(negedge clk); bus.run = 1'b1;
    @(negedge clk); check("run_to_fetch", 32'(bus.fetch_en), 32'd1);
    bus.run = 1'b0;
    bus.halt_req = 1'b1;
    @(negedge clk); bus.halt_req = 1'b0;
    wait_en(2, "exec_1");
    wait_en(2, "exec_2");
    wait_en(2, "exec_3");
    bus.halt_req = 1'b1;
    wait_halted("halted_a");
    bus.halt_req = 1'b0;
    check("instr_a", bus.instr_count, 32'd3);
    check("busy_a", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    check("sb_empty_a", 32'(exp_q.size()), 32'd0);
    check("cycle_a", bus.cycle_count, 32'd26);

    // Resume from HALT: branch then ALU, minimum instruction latency
    push_instr(OP_BRANCH, 5);
    push_instr(OP_ALU, 5);
    @(negedge clk); bus.run = 1'b1;
    @(negedge clk); check("resume_fetch", 32'(bus.fetch_en), 32'd1);
    check("resume_not_halted", 32'(bus.halted), 32'd0);
    t1 = cyc;
    bus.run = 1'b0;
    wait_en(0, "fetch_b2");
    check("min_instr_latency", 32'(cyc - t1), 32'd6);
    bus.halt_req = 1'b1;
    wait_halted("halted_b");
    bus.halt_req = 1'b0;
    check("instr_b", bus.instr_count, 32'd5);
    check("cycle_b", bus.cycle_count, 32'd40);

    // Spurious dones, then decode_done exactly on the timeout cycle
    auto_mask = 5'b11100;
    push_instr(OP_ALU, 5);
    @(negedge clk); bus.run = 1'b1;
    @(negedge clk); check("fetch_c", 32'(bus.fetch_en), 32'd1);
    bus.run = 1'b0;
    man_done[0] = 1'b1;
    @(negedge clk); man_done[0] = 1'b0;
    check("spur_fetch_in_en_cycle", 32'(en_vec), 32'd0);
    man_done[1] = 1'b1;
    @(negedge clk); man_done[1] = 1'b0;
    check("spur_decode_in_fetch", 32'(en_vec), 32'd0);
    check("busy_c", 32'(bus.busy), 32'd1);
    man_done[0] = 1'b1;
    @(negedge clk); man_done[0] = 1'b0;
    check("fetch_done_to_decode_en", 32'(bus.decode_en), 32'd1);
    repeat (8) @(negedge clk);
    check("no_err_before_limit", 32'(bus.error), 32'd0);
    man_done[1] = 1'b1;
    @(negedge clk); man_done[1] = 1'b0;
    check("done_at_limit_wins", 32'(bus.exec_en), 32'd1);
    check("done_at_limit_no_err", 32'(bus.error), 32'd0);
    bus.halt_req = 1'b1;
    wait_halted("halted_c");
    bus.halt_req = 1'b0;
    check("instr_c", bus.instr_count, 32'd6);
    repeat (60) @(negedge clk);
    check("sat_cycle", 32'(bus2.cycle_count), 32'd15);
    check("sat_instr", 32'(bus2.instr_count), 32'd15);

    // exec_done withheld -> timeout
    auto_mask = 5'b11011;
    push_instr(OP_ALU, 3);
    @(negedge clk); bus.run = 1'b1;
    wait_en(2, "exec_d");
    repeat (8) @(negedge clk);
    check("err_not_yet", 32'(bus.error), 32'd0);
    check("busy_before_err", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("err_set", 32'(bus.error), 32'd1);
    check("err_stage", 32'(bus.err_stage), 32'd2);
    check("err_busy", 32'(bus.busy), 32'd0);
    man_done[2] = 1'b1;
    @(negedge clk); man_done[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("err_sticky", 32'(bus.error), 32'd1);
    check("late_done_no_retire", bus.instr_count, 32'd6);

    // Reset clears error; then reset while waiting in MEM
    bus.run = 1'b0;
    rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    check("rst_clears_err", 32'(bus.error), 32'd0);
    check("rst_clears_instr", bus.instr_count, 32'd0);
    auto_mask = 5'b10111;
    push_instr(OP_LOAD, 4);
    @(negedge clk); bus.run = 1'b1;
    @(negedge clk); bus.run = 1'b0;
    wait_en(3, "mem_e");
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    check("rst_mid_mem_en", 32'(en_vec), 32'd0);
    check("rst_mid_mem_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_mem_cycle", bus.cycle_count, 32'd0);
    man_done[3] = 1'b1;
    @(negedge clk); man_done[3] = 1'b0;
    repeat (4) @(negedge clk);
    check("stale_mem_done_idle", 32'(bus.busy), 32'd0);
    check("stale_mem_done_instr", bus.instr_count, 32'd0);
    check("sb_empty_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
